// File: rtl/rx_frame_packer.sv
// Receive framer: strips preamble and length from the byte stream and packs the
// payload into BEAT_BYTES-wide beats with sof/eof/empty/err plus status counters.
module rx_frame_packer #(
    parameter int BEAT_BYTES     = 4,
    parameter int FIFO_ADD_WIDTH = 6,
    parameter int MAX_LEN        = 1518,
    parameter int TIMEOUT_CYC    = 65535,
    parameter int RESYNC_ON_SOF  = 1,
    localparam int EW            = (BEAT_BYTES > 1) ? $clog2(BEAT_BYTES) : 1,
    localparam int DW            = 8 * BEAT_BYTES
) (
    input  logic          i_rx_clk,
    input  logic          i_rx_rst_n,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_data_valid,
    input  logic          i_rx_sof,
    output logic          o_val,
    output logic          o_sof,
    output logic          o_eof,
    output logic [EW-1:0] o_empty,
    output logic [DW-1:0] o_data,
    output logic          o_err,
    input  logic          i_rdy,
    output logic          o_rx_9600_or_115200,
    output logic [15:0]   o_frame_cnt,
    output logic [15:0]   o_drop_cnt,
    output logic [15:0]   o_ovf_cnt
);

    // state  | meaning
    // IDLE   | discarding bytes until a sof-tagged 0x55/0xAA preamble
    // LEN_LO | next byte is length[7:0]
    // LEN_HI | next byte is length[15:8]; bounds checked here
    // DATA   | packing payload bytes into beats
    // ABORT  | closing an aborted frame, err beat only if its sof beat went out
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] LEN_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] ABORT  = 3'd4;

    localparam int          DEPTH     = 1 << FIFO_ADD_WIDTH;
    localparam int          PW        = FIFO_ADD_WIDTH + 1;
    localparam logic [15:0] TO_LIMIT  = 16'(TIMEOUT_CYC);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    logic [8:0]    fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full;
    logic [7:0]    head_byte;
    logic          head_sof;

    logic [2:0]    state;
    logic [7:0]    len_lo;
    logic [15:0]   rem;
    logic [15:0]   to_cnt;
    logic [EW-1:0] lane;
    logic [DW-1:0] pack, pack_next;
    logic          sof_sent, resync_pend;

    logic          in_frame, is_pre, timeout_hit, resync_hit, out_free;
    logic          last_byte, beat_done, len_bad, abort_go, pop;
    logic          drop_inc, frame_inc, ovf_inc;
    logic [15:0]   len_word;
    logic [EW-1:0] abort_empty;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                        (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign {head_sof, head_byte} = fifo_mem[rd_ptr[PW-2:0]];

    always_ff @(posedge i_rx_clk) begin
        if (i_rx_data_valid && !fifo_full)
            fifo_mem[wr_ptr[PW-2:0]] <= {i_rx_sof, i_rx_data};
    end

    assign in_frame    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
    assign is_pre      = (head_byte == 8'h55) || (head_byte == 8'hAA);
    assign timeout_hit = in_frame && (to_cnt == TO_LIMIT);
    assign resync_hit  = (RESYNC_ON_SOF != 0) && in_frame && !fifo_empty && head_sof && is_pre;
    assign out_free    = !o_val || i_rdy;
    assign last_byte   = (rem == 16'd1);
    assign beat_done   = last_byte || (lane == EW'(BEAT_BYTES - 1));
    assign len_word    = {head_byte, len_lo};
    assign len_bad     = (len_word == 16'd0) || (len_word > MAX_LEN_W);
    assign abort_go    = !sof_sent || out_free;
    // An abort with nothing pending still needs a beat, reported as one empty-lane short of full.
    assign abort_empty = (lane == '0) ? EW'(BEAT_BYTES - 1) : EW'(BEAT_BYTES - int'(lane));

    always_comb begin
        pop = 1'b0;
        if (!fifo_empty && !timeout_hit) begin
            case (state)
                IDLE, LEN_LO, LEN_HI: pop = 1'b1;
                DATA:                 pop = resync_hit || !beat_done || out_free;
                default:              pop = 1'b0;
            endcase
        end
    end

    always_comb begin
        pack_next = pack;
        for (int i = 0; i < BEAT_BYTES; i++)
            if (lane == EW'(i)) pack_next[8*i +: 8] = head_byte;
    end

    assign drop_inc  = (state == LEN_HI && pop && !resync_hit && len_bad) ||
                       (state == ABORT && abort_go);
    assign frame_inc = (state == DATA) && pop && !resync_hit && last_byte;
    assign ovf_inc   = i_rx_data_valid && fifo_full;

    always_ff @(posedge i_rx_clk or negedge i_rx_rst_n) begin
        if (!i_rx_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_frame_cnt <= '0;
            o_drop_cnt  <= '0;
            o_ovf_cnt   <= '0;
        end else begin
            if (i_rx_data_valid && !fifo_full) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (frame_inc && o_frame_cnt != 16'hFFFF) o_frame_cnt <= o_frame_cnt + 16'd1;
            if (drop_inc && o_drop_cnt != 16'hFFFF)   o_drop_cnt  <= o_drop_cnt + 16'd1;
            if (ovf_inc && o_ovf_cnt != 16'hFFFF)     o_ovf_cnt   <= o_ovf_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_rx_clk or negedge i_rx_rst_n) begin
        if (!i_rx_rst_n) begin
            state               <= IDLE;
            len_lo              <= '0;
            rem                 <= '0;
            to_cnt              <= '0;
            lane                <= '0;
            pack                <= '0;
            sof_sent            <= 1'b0;
            resync_pend         <= 1'b0;
            o_rx_9600_or_115200 <= 1'b0;
            o_val               <= 1'b0;
            o_sof               <= 1'b0;
            o_eof               <= 1'b0;
            o_err               <= 1'b0;
            o_empty             <= '0;
            o_data              <= '0;
        end else begin
            if (o_val && i_rdy) o_val <= 1'b0;

            if (pop || !in_frame)
                to_cnt <= '0;
            else if (fifo_empty)
                to_cnt <= to_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (pop && head_sof && is_pre) begin
                        o_rx_9600_or_115200 <= (head_byte == 8'h55);
                        sof_sent            <= 1'b0;
                        state               <= LEN_LO;
                    end
                end
                LEN_LO, LEN_HI, DATA: begin
                    if (timeout_hit) begin
                        resync_pend <= 1'b0;
                        state       <= ABORT;
                    end else if (pop && resync_hit) begin
                        o_rx_9600_or_115200 <= (head_byte == 8'h55);
                        resync_pend         <= 1'b1;
                        state               <= ABORT;
                    end else if (pop) begin
                        if (state == LEN_LO) begin
                            len_lo <= head_byte;
                            state  <= LEN_HI;
                        end else if (state == LEN_HI) begin
                            if (len_bad) begin
                                state <= IDLE;
                            end else begin
                                rem      <= len_word;
                                lane     <= '0;
                                pack     <= '0;
                                sof_sent <= 1'b0;
                                state    <= DATA;
                            end
                        end else begin
                            rem <= rem - 16'd1;
                            if (beat_done) begin
                                o_val    <= 1'b1;
                                o_data   <= pack_next;
                                o_sof    <= !sof_sent;
                                o_eof    <= last_byte;
                                o_err    <= 1'b0;
                                o_empty  <= last_byte ? EW'(BEAT_BYTES - 1) - lane : '0;
                                sof_sent <= 1'b1;
                                lane     <= '0;
                                pack     <= '0;
                                if (last_byte) state <= IDLE;
                            end else begin
                                lane <= lane + EW'(1);
                                pack <= pack_next;
                            end
                        end
                    end
                end
                ABORT: begin
                    if (abort_go) begin
                        if (sof_sent) begin
                            o_val   <= 1'b1;
                            o_data  <= pack;
                            o_sof   <= 1'b0;
                            o_eof   <= 1'b1;
                            o_err   <= 1'b1;
                            o_empty <= abort_empty;
                        end
                        sof_sent <= 1'b0;
                        lane     <= '0;
                        pack     <= '0;
                        state    <= resync_pend ? LEN_LO : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_packer.sv
// Directed bench for rx_frame_packer: framing, length bounds, timeout, resync,
// back-to-back frames, backpressure with overflow and reset mid-frame.
module tb_rx_frame_packer;

    logic        i_rx_clk = 1'b0;
    logic        i_rx_rst_n = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_data_valid = 1'b0;
    logic        i_rx_sof = 1'b0;
    logic        i_rdy = 1'b1;
    logic        o_val, o_sof, o_eof, o_err, o_rx_9600_or_115200;
    logic [1:0]  o_empty;
    logic [31:0] o_data;
    logic [15:0] o_frame_cnt, o_drop_cnt, o_ovf_cnt;

    always #5 i_rx_clk = ~i_rx_clk;

    rx_frame_packer #(
        .BEAT_BYTES(4), .FIFO_ADD_WIDTH(6), .MAX_LEN(1518),
        .TIMEOUT_CYC(16), .RESYNC_ON_SOF(1)
    ) dut (
        .i_rx_clk(i_rx_clk), .i_rx_rst_n(i_rx_rst_n),
        .i_rx_data(i_rx_data), .i_rx_data_valid(i_rx_data_valid), .i_rx_sof(i_rx_sof),
        .o_val(o_val), .o_sof(o_sof), .o_eof(o_eof), .o_empty(o_empty),
        .o_data(o_data), .o_err(o_err), .i_rdy(i_rdy),
        .o_rx_9600_or_115200(o_rx_9600_or_115200),
        .o_frame_cnt(o_frame_cnt), .o_drop_cnt(o_drop_cnt), .o_ovf_cnt(o_ovf_cnt)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eof;
        logic        err;
        logic [1:0]  empty;
    } beat_t;

    beat_t beats[$];
    beat_t exp_beats[$];
    int checks = 0, errors = 0;
    int exp_frame = 0, exp_drop = 0, exp_ovf = 0;

    // Record every beat that transfers at the next rising edge.
    always @(negedge i_rx_clk)
        if (i_rx_rst_n && o_val && i_rdy)
            beats.push_back('{o_data, o_sof, o_eof, o_err, o_empty});

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic send(input logic [7:0] b, input logic s);
        i_rx_data = b; i_rx_sof = s; i_rx_data_valid = 1'b1;
        @(posedge i_rx_clk); #1;
        i_rx_data_valid = 1'b0; i_rx_sof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_rx_clk);
        #1;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (beats.size() < n && k < budget) begin
            @(posedge i_rx_clk); #1;
            k++;
        end
        idle(1);
    endtask

    task automatic compare_beats(input string name);
        for (int i = 0; i < exp_beats.size(); i++) begin
            checks++;
            if (i >= beats.size()) begin
                errors++;
                $display("FAIL %s beat%0d missing, got %0d beats want %0d", name, i, beats.size(), exp_beats.size());
            end else if (beats[i] !== exp_beats[i]) begin
                errors++;
                $display("FAIL %s beat%0d got %h want %h", name, i, beats[i], exp_beats[i]);
            end
        end
        checks++;
        if (beats.size() !== exp_beats.size()) begin
            errors++;
            $display("FAIL %s beat_count got %0d want %0d", name, beats.size(), exp_beats.size());
        end
    endtask

    task automatic check_counters(input string name);
        checks++;
        if ({o_frame_cnt, o_drop_cnt, o_ovf_cnt} !== {16'(exp_frame), 16'(exp_drop), 16'(exp_ovf)}) begin
            errors++;
            $display("FAIL %s counters got frame=%0d drop=%0d ovf=%0d want frame=%0d drop=%0d ovf=%0d",
                     name, o_frame_cnt, o_drop_cnt, o_ovf_cnt, exp_frame, exp_drop, exp_ovf);
        end
    endtask

    task automatic do_reset();
        i_rx_rst_n = 1'b0; i_rx_data_valid = 1'b0; i_rx_sof = 1'b0; i_rdy = 1'b1;
        repeat (3) @(posedge i_rx_clk);
        #2 i_rx_rst_n = 1'b1;
        @(posedge i_rx_clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_val, o_sof, o_eof, o_err, o_empty, o_data, o_rx_9600_or_115200} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs got val=%b sof=%b eof=%b err=%b empty=%0d data=%h baud=%b want all 0",
                     o_val, o_sof, o_eof, o_err, o_empty, o_data, o_rx_9600_or_115200);
        end
        check_counters("reset");
    endtask

    task automatic test_basic();
        beats.delete();
        send(8'h55, 1); send(8'h05, 0); send(8'h00, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        checks++;
        if (o_val !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency_early o_val got %b want 0", o_val);
        end
        send(8'h55, 0);
        checks++;
        if (o_val !== 1'b1 || o_data !== 32'h44332211) begin
            errors++;
            $display("FAIL basic_latency got val=%b data=%h want val=1 data=44332211", o_val, o_data);
        end
        wait_beats(2, 20);
        exp_beats = '{'{32'h44332211, 1'b1, 1'b0, 1'b0, 2'd0},
                      '{32'h00000055, 1'b0, 1'b1, 1'b0, 2'd3}};
        compare_beats("basic");
        exp_frame++;
        check_counters("basic");
        checks++;
        if (o_rx_9600_or_115200 !== 1'b1) begin
            errors++;
            $display("FAIL basic_baud got %b want 1", o_rx_9600_or_115200);
        end
    endtask

    task automatic test_len_zero();
        beats.delete();
        send(8'hAA, 1); send(8'h00, 0); send(8'h00, 0);
        idle(20);
        exp_beats.delete();
        compare_beats("len_zero");
        exp_drop++;
        check_counters("len_zero");
        checks++;
        if (o_rx_9600_or_115200 !== 1'b0) begin
            errors++;
            $display("FAIL len_zero_baud got %b want 0", o_rx_9600_or_115200);
        end
    endtask

    task automatic test_len_big();
        beats.delete();
        send(8'h55, 1); send(8'h00, 0); send(8'h06, 0);
        send(8'h55, 1); send(8'hEF, 0); send(8'h05, 0);
        idle(20);
        exp_beats.delete();
        compare_beats("len_big");
        exp_drop += 2;
        check_counters("len_big");
    endtask

    task automatic test_timeout();
        int n = 0;
        beats.delete();
        send(8'hAA, 1); send(8'h08, 0); send(8'h00, 0);
        for (int i = 1; i <= 5; i++) send(8'(i), 0);
        while (!(o_val && o_eof) && n < 40) begin
            @(posedge i_rx_clk); #1;
            n++;
        end
        checks++;
        if (n < 16 || n > 24) begin
            errors++;
            $display("FAIL timeout_delay got %0d cycles want 16..24", n);
        end
        wait_beats(2, 5);
        exp_beats = '{'{32'h04030201, 1'b1, 1'b0, 1'b0, 2'd0},
                      '{32'h00000005, 1'b0, 1'b1, 1'b1, 2'd3}};
        compare_beats("timeout");
        exp_drop++;
        check_counters("timeout");
    endtask

    task automatic test_resync();
        beats.delete();
        send(8'hAA, 1); send(8'h08, 0); send(8'h00, 0); send(8'h11, 0); send(8'h22, 0);
        send(8'h55, 1); send(8'h02, 0); send(8'h00, 0); send(8'hA1, 0); send(8'hB2, 0);
        wait_beats(1, 30);
        idle(5);
        exp_beats = '{'{32'h0000B2A1, 1'b1, 1'b1, 1'b0, 2'd2}};
        compare_beats("resync");
        exp_drop++;
        exp_frame++;
        check_counters("resync");
        checks++;
        if (o_rx_9600_or_115200 !== 1'b1) begin
            errors++;
            $display("FAIL resync_baud got %b want 1", o_rx_9600_or_115200);
        end
    endtask

    task automatic test_back_to_back();
        beats.delete();
        send(8'h55, 1); send(8'h04, 0); send(8'h00, 0);
        send(8'h0A, 0); send(8'h0B, 0); send(8'h0C, 0); send(8'h0D, 0);
        send(8'hAA, 1); send(8'h01, 0); send(8'h00, 0); send(8'h0E, 0);
        wait_beats(2, 20);
        exp_beats = '{'{32'h0D0C0B0A, 1'b1, 1'b1, 1'b0, 2'd0},
                      '{32'h0000000E, 1'b1, 1'b1, 1'b0, 2'd3}};
        compare_beats("back_to_back");
        exp_frame += 2;
        check_counters("back_to_back");
        checks++;
        if (o_rx_9600_or_115200 !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_baud got %b want 0", o_rx_9600_or_115200);
        end
    endtask

    task automatic test_hold();
        logic [38:0] snap;
        int unstable = 0;
        beats.delete();
        i_rdy = 1'b0;
        send(8'h55, 1); send(8'h64, 0); send(8'h00, 0);
        for (int i = 1; i <= 100; i++) send(8'(i), 0);
        checks++;
        if ({o_val, o_sof, o_eof, o_err, o_data} !== {4'b1100, 32'h04030201}) begin
            errors++;
            $display("FAIL hold_first_beat got val=%b sof=%b eof=%b err=%b data=%h want 1 1 0 0 04030201",
                     o_val, o_sof, o_eof, o_err, o_data);
        end
        snap = {o_val, o_sof, o_eof, o_err, o_empty, o_data};
        for (int i = 0; i < 97; i++) begin
            @(negedge i_rx_clk);
            if ({o_val, o_sof, o_eof, o_err, o_empty, o_data} !== snap) unstable++;
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL hold_stable got %0d changed cycles want 0", unstable);
        end
        exp_ovf += 29;
        check_counters("hold_ovf");
        @(posedge i_rx_clk); #1;
        i_rdy = 1'b1;
        wait_beats(18, 200);
        idle(5);
        exp_beats.delete();
        for (int i = 0; i < 17; i++)
            exp_beats.push_back('{{8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)},
                                  (i == 0), 1'b0, 1'b0, 2'd0});
        exp_beats.push_back('{32'h00474645, 1'b0, 1'b1, 1'b1, 2'd1});
        compare_beats("hold");
        exp_drop++;
        check_counters("hold_end");
    endtask

    task automatic test_reset_mid();
        beats.delete();
        send(8'h55, 1); send(8'h08, 0); send(8'h00, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        #2 i_rx_rst_n = 1'b0;
        #1;
        exp_frame = 0; exp_drop = 0; exp_ovf = 0;
        checks++;
        if (o_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_val got %b want 0", o_val);
        end
        check_counters("reset_mid");
        @(posedge i_rx_clk); #2;
        i_rx_rst_n = 1'b1;
        idle(40);
        exp_beats.delete();
        compare_beats("reset_mid_silent");
        send(8'h55, 1); send(8'h01, 0); send(8'h00, 0); send(8'h77, 0);
        wait_beats(1, 20);
        exp_beats = '{'{32'h00000077, 1'b1, 1'b1, 1'b0, 2'd3}};
        compare_beats("reset_mid_recover");
        exp_frame++;
        check_counters("reset_mid_recover");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_len_big();
        test_timeout();
        test_resync();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
